// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Byte-offset bits inside one 64-bit memory word
  localparam int WORD_OFF_BITS = 3;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - combinational two-way round-robin pick between fetch and load/store
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic  req_i,
  input  logic  req_d,
  input  port_t last_grant,
  output port_t grant,
  output logic  valid
);

  // A tie goes to whichever port did not win last time
  always_comb begin
    valid = req_i | req_d;
    grant = PORT_I;
    if (req_i && req_d) begin
      grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
    end else if (req_d) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one 64-bit memory between instruction fetch and load/store
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ack,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_din,
  output logic              mem_wr,
  input  logic [63:0]       mem_dout,
  output logic              busy
);

  localparam int CNT_W = 3;

  arb_state_t        r_state;
  port_t             r_last_grant;
  port_t             r_port;
  logic              r_we;
  logic              r_err;
  logic              r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_i_rdata;
  logic [63:0]       r_d_rdata;

  port_t             w_grant;
  logic              w_valid;
  logic              w_d_misaligned;
  logic [ADDR_W-1:0] w_i_addr_al;
  logic [ADDR_W-1:0] w_d_addr_al;
  logic              w_unused_i_addr;

  mem_arb_rr u_rr (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .valid      (w_valid)
  );

  // Word-aligned memory addresses for each port; fetch byte lanes [1:0] are don't-care
  assign w_i_addr_al     = ADDR_W'({i_addr[31:WORD_OFF_BITS], {WORD_OFF_BITS{1'b0}}});
  assign w_d_addr_al     = {d_addr[ADDR_W-1:WORD_OFF_BITS], {WORD_OFF_BITS{1'b0}}};
  assign w_d_misaligned  = |d_addr[WORD_OFF_BITS-1:0];
  assign w_unused_i_addr = ^i_addr[1:0];

  // Arbitration, access sequencing and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_D;
      r_port       <= PORT_I;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_hi         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_last_grant <= w_grant;
            r_port       <= w_grant;
            if (w_grant == PORT_I) begin
              r_addr  <= w_i_addr_al;
              r_hi    <= i_addr[2];
              r_we    <= 1'b0;
              r_err   <= 1'b0;
              r_state <= ACCESS;
            end else if (w_d_misaligned) begin
              // Rejected without touching memory: straight to the response
              r_we    <= 1'b0;
              r_err   <= 1'b1;
              r_state <= RESP;
            end else begin
              r_addr  <= w_d_addr_al;
              r_we    <= d_we;
              r_wdata <= d_wdata;
              r_err   <= 1'b0;
              r_state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (r_we) begin
            r_state <= RESP;
          end else begin
            r_cnt   <= CNT_W'(MEM_LAT);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            if (r_port == PORT_I) begin
              r_i_rdata <= r_hi ? mem_dout[63:32] : mem_dout[31:0];
            end else begin
              r_d_rdata <= mem_dout;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of state so an asynchronous reset clears them at once
  assign busy     = (r_state != IDLE);
  assign mem_wr   = (r_state == ACCESS) && r_we;
  assign i_ack    = (r_state == RESP) && (r_port == PORT_I);
  assign d_ack    = (r_state == RESP) && (r_port == PORT_D);
  assign d_err    = d_ack && r_err;
  assign mem_addr = r_addr;
  assign mem_din  = r_wdata;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        d_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_din;
  logic        mem_wr;
  logic [63:0] mem_dout;
  logic        busy;

  logic        i3_req;
  logic [31:0] i3_addr;
  logic        i3_ack;
  logic [31:0] unused_i3_rdata;
  logic        d3_req;
  logic        d3_we;
  logic [63:0] d3_addr;
  logic [63:0] d3_wdata;
  logic        d3_ack;
  logic [63:0] d3_rdata;
  logic        d3_err;
  logic [63:0] mem3_addr;
  logic [63:0] unused_mem3_din;
  logic        mem3_wr;
  logic [63:0] mem3_dout;
  logic        busy3;

  mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(64)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(LAT3), .ADDR_W(64)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i3_req), .i_addr(i3_addr), .i_ack(i3_ack), .i_rdata(unused_i3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_ack(d3_ack), .d_rdata(d3_rdata), .d_err(d3_err),
    .mem_addr(mem3_addr), .mem_din(unused_mem3_din), .mem_wr(mem3_wr), .mem_dout(mem3_dout),
    .busy(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int n_cmp;
  int n_bad;
  int cyc;

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b required %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_word(input int k);
    if (k == 32) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {32'(k) * 32'h9E37_79B1, ~(32'(k) * 32'h85EB_CA6B)};
  endfunction

  // Physical memory seen by the DUT: registered read, MEM_LAT-deep pipeline
  logic [63:0] phys_mem [128];
  logic [63:0] rd_pipe  [LAT];
  assign mem_dout = rd_pipe[LAT-1];

  initial begin
    for (int k = 0; k < 128; k++) phys_mem[k] = init_word(k);
    for (int k = 0; k < LAT; k++) rd_pipe[k] = '0;
    forever begin
      @(posedge clk);
      rd_pipe[0] <= phys_mem[mem_addr[9:3]];
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
      if (mem_wr) phys_mem[mem_addr[9:3]] <= mem_din;
    end
  end

  // Memory for the slow-latency instance: contents are a function of address
  logic [63:0] rd_pipe3 [LAT3];
  assign mem3_dout = rd_pipe3[LAT3-1];

  initial begin
    for (int k = 0; k < LAT3; k++) rd_pipe3[k] = '0;
    forever begin
      @(posedge clk);
      rd_pipe3[0] <= {mem3_addr[31:0] ^ 32'hDEAD_BEEF, mem3_addr[31:0]};
      for (int k = 1; k < LAT3; k++) rd_pipe3[k] <= rd_pipe3[k-1];
    end
  end

  // Reference model: whole transactions with latencies derived from the rules
  typedef struct {
    port_t       port;
    logic [63:0] data;
    logic        err;
    logic        is_wr;
    logic [63:0] waddr;
    logic [63:0] wdata;
    int          ack_cyc;
  } exp_t;

  exp_t        q[$];
  port_t       grant_log[$];
  logic [63:0] ref_mem [128];
  int          free_at;
  port_t       m_last;
  logic [63:0] m_drdata;
  exp_t        m_e;
  port_t       m_w;
  int          m_lat;
  logic [63:0] m_word;

  initial begin
    cyc      = 0;
    free_at  = 0;
    m_last   = PORT_D;
    m_drdata = '0;
    for (int k = 0; k < 128; k++) ref_mem[k] = init_word(k);
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!rst_n) begin
        m_last   = PORT_D;
        free_at  = cyc;
        m_drdata = '0;
        q.delete();
      end else if (cyc >= free_at && (i_req || d_req)) begin
        if (i_req && d_req) m_w = (m_last == PORT_D) ? PORT_I : PORT_D;
        else                m_w = i_req ? PORT_I : PORT_D;
        m_last = m_w;
        m_e = '{port: m_w, data: 64'h0, err: 1'b0, is_wr: 1'b0,
                waddr: 64'h0, wdata: 64'h0, ack_cyc: 0};
        if (m_w == PORT_I) begin
          m_word    = ref_mem[i_addr[9:3]];
          m_e.data  = i_addr[2] ? 64'(m_word[63:32]) : 64'(m_word[31:0]);
          m_lat     = 2 + LAT;
        end else if (d_addr[2:0] != 3'd0) begin
          m_e.err   = 1'b1;
          m_e.data  = m_drdata;
          m_lat     = 1;
        end else if (d_we) begin
          ref_mem[d_addr[9:3]] = d_wdata;
          m_e.is_wr = 1'b1;
          m_e.waddr = d_addr;
          m_e.wdata = d_wdata;
          m_e.data  = m_drdata;
          m_lat     = 2;
        end else begin
          m_e.data  = ref_mem[d_addr[9:3]];
          m_drdata  = m_e.data;
          m_lat     = 2 + LAT;
        end
        m_e.ack_cyc = cyc + m_lat - 1;
        free_at     = cyc + m_lat + 1;
        q.push_back(m_e);
      end
    end
  end

  // Monitor: pops an expectation whenever an ack appears
  exp_t mon_e;
  int   wr_cnt;

  initial begin
    wr_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        wr_cnt = 0;
      end else begin
        chkb("busy", busy, q.size() > 0);
        if (mem_wr) begin
          wr_cnt++;
          if (q.size() == 0) chkb("mem_wr_idle", 1'b1, 1'b0);
          else begin
            chkw("mem_addr_wr", mem_addr, q[0].waddr);
            chkw("mem_din_wr", mem_din, q[0].wdata);
          end
        end
        if (i_ack && d_ack) chkb("dual_ack", 1'b1, 1'b0);
        if (i_ack || d_ack) begin
          if (q.size() == 0) chkb("spurious_ack", 1'b1, 1'b0);
          else begin
            mon_e = q.pop_front();
            chkb("ack_port_d", d_ack, mon_e.port == PORT_D);
            chkw("ack_cycle", 64'(cyc), 64'(mon_e.ack_cyc));
            if (mon_e.port == PORT_I) chkw("i_rdata", 64'(i_rdata), mon_e.data);
            else begin
              chkw("d_rdata", d_rdata, mon_e.data);
              chkb("d_err", d_err, mon_e.err);
            end
            chkw("mem_wr_cycles", 64'(wr_cnt), 64'(mon_e.is_wr));
            wr_cnt = 0;
            grant_log.push_back(mon_e.port);
          end
        end else if (q.size() > 0 && cyc > q[0].ack_cyc) begin
          chkb("ack_missing", 1'b0, 1'b1);
          void'(q.pop_front());
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic do_i(input logic [31:0] a);
    i_req  = 1'b1;
    i_addr = a;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      #1;
      if (i_ack) begin
        i_req = 1'b0;
        return;
      end
    end
    chkb("i_ack_wait", 1'b0, 1'b1);
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [63:0] a, input logic [63:0] wd);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      #1;
      if (d_ack) begin
        d_req = 1'b0;
        return;
      end
    end
    chkb("d_ack_wait", 1'b0, 1'b1);
    d_req = 1'b0;
  endtask

  // Called at a falling edge: asserts reset and checks outputs clear immediately
  task automatic reset_now();
    rst_n = 1'b0;
    grant_log.delete();
    #1;
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_i_ack", i_ack, 1'b0);
    chkb("rst_d_ack", d_ack, 1'b0);
    chkb("rst_mem_wr", mem_wr, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_busy();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (busy) return;
    end
    chkb("wait_busy", 1'b0, 1'b1);
  endtask

  task automatic rand_i(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_i({22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))});
    end
  endtask

  task automatic rand_d(input int n);
    logic [6:0] idx;
    logic [2:0] off;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      idx = 7'($urandom_range(0, 127));
      off = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      do_d(1'($urandom_range(0, 1)), {54'h0, idx, off}, {$urandom, $urandom});
    end
  endtask

  port_t exp_order [4];
  int    ack_at;
  int    busy_n;
  logic  d3_err_seen;
  logic  other3_seen;

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    i_req    = 1'b0;  i_addr  = '0;
    d_req    = 1'b0;  d_we    = 1'b0;  d_addr  = '0;  d_wdata  = '0;
    i3_req   = 1'b0;  i3_addr = '0;
    d3_req   = 1'b0;  d3_we   = 1'b0;  d3_addr = '0;  d3_wdata = '0;
    exp_order = '{PORT_I, PORT_D, PORT_I, PORT_D};

    repeat (2) @(negedge clk);
    chkb("reset_busy", busy, 1'b0);
    chkb("reset_i_ack", i_ack, 1'b0);
    chkb("reset_d_ack", d_ack, 1'b0);
    chkb("reset_mem_wr", mem_wr, 1'b0);
    chkw("reset_i_rdata", 64'(i_rdata), 64'h0);
    chkw("reset_d_rdata", d_rdata, 64'h0);
    chkw("reset_mem_addr", mem_addr, 64'h0);
    chkw("reset_mem_din", mem_din, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch of the upper half of word 0x100
    do_i(32'h0000_0104);
    chkw("fetch_word", 64'(i_rdata), 64'h0000_0000_AAAA_BBBB);

    // Store then load back
    do_d(1'b1, 64'h40, 64'h1122_3344_5566_7788);
    do_d(1'b0, 64'h40, 64'h0);
    chkw("load_back", d_rdata, 64'h1122_3344_5566_7788);

    // Misaligned store is rejected and leaves memory alone
    do_d(1'b1, 64'h43, 64'hDEAD_DEAD_DEAD_DEAD);
    @(negedge clk);
    chkw("misalign_mem", phys_mem[8], 64'h1122_3344_5566_7788);

    // Both ports held for four accesses straight after reset
    @(negedge clk);
    reset_now();
    fork
      begin do_i(32'h10); do_i(32'h18); end
      begin do_d(1'b0, 64'h20, 64'h0); do_d(1'b0, 64'h28, 64'h0); end
    join
    @(negedge clk);
    #3;
    chkw("grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < grant_log.size()) chkb("grant_order", grant_log[k] == PORT_D, exp_order[k] == PORT_D);
    end

    // Reset while a fetch is in WAIT; held requests then replay with I first
    fork
      do_i(32'h30);
      do_d(1'b0, 64'h38, 64'h0);
      begin
        wait_busy();
        @(negedge clk);
        reset_now();
      end
    join
    @(negedge clk);
    #3;
    chkw("post_rst_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() > 0) chkb("post_rst_first_i", grant_log[0] == PORT_I, 1'b1);

    // Reset while a store is strobing the memory
    fork
      do_d(1'b1, 64'h50, 64'h5555_6666_7777_8888);
      begin
        wait_busy();
        chkb("pre_rst_mem_wr", mem_wr, 1'b1);
        reset_now();
      end
    join
    @(negedge clk);
    chkw("store_after_abort", phys_mem[10], 64'h5555_6666_7777_8888);

    // Random traffic on both ports
    fork
      rand_i(40);
      rand_d(40);
    join

    // Slow-memory instance: single load
    @(negedge clk);
    d3_req = 1'b1; d3_we = 1'b0; d3_addr = 64'h80;
    ack_at = 0; busy_n = 0; d3_err_seen = 1'b0; other3_seen = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      #1;
      if (busy3) busy_n++;
      if (i3_ack || mem3_wr) other3_seen = 1'b1;
      if (d3_ack && ack_at == 0) begin
        ack_at      = t;
        d3_err_seen = d3_err;
        d3_req      = 1'b0;
      end
    end
    chkw("lat3_ack_cycle", 64'(ack_at), 64'd5);
    chkw("lat3_busy_cycles", 64'(busy_n), 64'd5);
    chkw("lat3_rdata", d3_rdata, {32'hDEAD_BEEF ^ 32'h80, 32'h80});
    chkb("lat3_err", d3_err_seen, 1'b0);
    chkb("lat3_other_activity", other3_seen, 1'b0);

    for (int t = 0; t < 50 && q.size() > 0; t++) @(negedge clk);
    chkw("drain", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
